// File: rtl/apu_fpu_credit_adapter.sv
// apu_fpu_credit_adapter
//   Bridges the shared APU interconnect to an fpnew-style FPU core.
//   - Request side: the APU opcode and flag words are decoded into FPU control
//     fields and passed straight through, so a grant adds no latency.
//   - Response side: results land in a RESP_DEPTH-deep FIFO, so apu_rready_i
//     can stall responses without back-pressuring the FPU.
//   - Credits: a counter caps issued-but-not-popped operations at RESP_DEPTH,
//     so the FIFO always has room and fpu_out_ready_o can be tied high.
//   - Flush: flush_i clears the counter and the FIFO on the next edge.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush_i / fpu_flush_o       drop all outstanding work (forwarded to the FPU)
//   apu_req_i/apu_gnt_o, apu_ID_i, apu_operands_i, apu_op_i, apu_flags_i
//                               APU request channel
//   apu_rvalid_o/apu_rready_i, apu_rdata_o, apu_rflags_o, apu_rID_o
//                               APU response channel (head of the response FIFO)
//   fpu_in_valid_o/fpu_in_ready_i, fpu_operands_o, fpu_op_o, fpu_op_mod_o,
//   fpu_vec_op_o, fpu_rnd_mode_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o,
//   fpu_tag_o                   FPU issue channel
//   fpu_out_valid_i/fpu_out_ready_o, fpu_result_i, fpu_status_i, fpu_tag_i
//                               FPU result channel
//   busy_o, credits_o           credit occupancy
module apu_fpu_credit_adapter #(
    parameter int unsigned ID_WIDTH        = 9,
    parameter int unsigned NB_ARGS         = 3,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned OPCODE_WIDTH    = 6,
    parameter int unsigned FLAGS_IN_WIDTH  = 15,
    parameter int unsigned FLAGS_OUT_WIDTH = 5,
    parameter int unsigned RESP_DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,

    input  logic                            apu_req_i,
    output logic                            apu_gnt_o,
    input  logic [ID_WIDTH-1:0]             apu_ID_i,
    input  logic [NB_ARGS*DATA_WIDTH-1:0]   apu_operands_i,
    input  logic [OPCODE_WIDTH-1:0]         apu_op_i,
    input  logic [FLAGS_IN_WIDTH-1:0]       apu_flags_i,

    input  logic                            apu_rready_i,
    output logic                            apu_rvalid_o,
    output logic [DATA_WIDTH-1:0]           apu_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]      apu_rflags_o,
    output logic [ID_WIDTH-1:0]             apu_rID_o,

    output logic                            fpu_in_valid_o,
    input  logic                            fpu_in_ready_i,
    output logic [NB_ARGS*DATA_WIDTH-1:0]   fpu_operands_o,
    output logic [3:0]                      fpu_op_o,
    output logic                            fpu_op_mod_o,
    output logic                            fpu_vec_op_o,
    output logic [2:0]                      fpu_rnd_mode_o,
    output logic [2:0]                      fpu_src_fmt_o,
    output logic [2:0]                      fpu_dst_fmt_o,
    output logic [1:0]                      fpu_int_fmt_o,
    output logic [ID_WIDTH-1:0]             fpu_tag_o,

    input  logic                            fpu_out_valid_i,
    output logic                            fpu_out_ready_o,
    input  logic [DATA_WIDTH-1:0]           fpu_result_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]      fpu_status_i,
    input  logic [ID_WIDTH-1:0]             fpu_tag_i,

    output logic                            fpu_flush_o,
    output logic                            busy_o,
    output logic [$clog2(RESP_DEPTH+1)-1:0] credits_o
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]      result;
        logic [FLAGS_OUT_WIDTH-1:0] status;
        logic [ID_WIDTH-1:0]        tag;
    } resp_t;

    resp_t             mem [RESP_DEPTH];
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [CNT_W-1:0]  fill, fill_next;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_next;
    logic              can_issue;
    logic              issue;
    logic              push;
    logic              pop;
    logic              full;
    resp_t             head;

    // Pointer increment that wraps modulo RESP_DEPTH (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Field decode: pure pass-through.
    assign {fpu_vec_op_o, fpu_op_mod_o, fpu_op_o} = apu_op_i[5:0];
    assign {fpu_int_fmt_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_rnd_mode_o} = apu_flags_i[10:0];
    assign fpu_operands_o = apu_operands_i;
    assign fpu_tag_o      = apu_ID_i;

    // Flag bits above the decoded field carry no meaning here.
    generate
        if (FLAGS_IN_WIDTH > 11) begin : g_flags_hi
            logic flags_hi_unused;
            assign flags_hi_unused = ^apu_flags_i[FLAGS_IN_WIDTH-1:11];
        end
    endgenerate

    // Issue side: the grant depends only on registered credits, ready and flush.
    assign can_issue      = (cnt < DEPTH_C) && !flush_i;
    assign apu_gnt_o      = fpu_in_ready_i && can_issue;
    assign fpu_in_valid_o = apu_req_i && can_issue;
    assign issue          = apu_req_i && apu_gnt_o;

    // Response side: credits guarantee space, so the FPU is never stalled.
    assign fpu_out_ready_o = 1'b1;
    assign fpu_flush_o     = flush_i;
    assign push            = fpu_out_valid_i && !flush_i;
    assign full            = (fill == DEPTH_C);
    assign apu_rvalid_o    = (fill != '0);
    assign pop             = apu_rvalid_o && apu_rready_i;

    assign head         = mem[rd_ptr];
    assign apu_rdata_o  = head.result;
    assign apu_rflags_o = head.status;
    assign apu_rID_o    = head.tag;

    assign busy_o    = (cnt != '0);
    assign credits_o = cnt;

    // Next-state for credits and FIFO bookkeeping.
    always_comb begin
        cnt_next    = cnt;
        fill_next   = fill;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (flush_i) begin
            cnt_next    = '0;
            fill_next   = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (issue && !pop) begin
                cnt_next = cnt + CNT_W'(1);
            end else if (!issue && pop) begin
                cnt_next = cnt - CNT_W'(1);
            end
            if (push && !pop) begin
                fill_next = fill + CNT_W'(1);
            end else if (!push && pop) begin
                fill_next = fill - CNT_W'(1);
            end
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr);
            end
        end
    end

    // Credit and pointer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            fill   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            cnt    <= cnt_next;
            fill   <= fill_next;
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
        end
    end

    // Response storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RESP_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};
        end
    end

    // A push into a full FIFO without a pop means the FPU broke the credit contract.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: tb/tb_apu_fpu_credit_adapter.sv
// Directed testbench for apu_fpu_credit_adapter with a two-stage FPU model.
module tb_apu_fpu_credit_adapter;

    logic         clk;
    logic         rst_n;
    logic         flush_i;
    logic         apu_req_i;
    logic         apu_gnt_o;
    logic [8:0]   apu_ID_i;
    logic [95:0]  apu_operands_i;
    logic [5:0]   apu_op_i;
    logic [14:0]  apu_flags_i;
    logic         apu_rready_i;
    logic         apu_rvalid_o;
    logic [31:0]  apu_rdata_o;
    logic [4:0]   apu_rflags_o;
    logic [8:0]   apu_rID_o;
    logic         fpu_in_valid_o;
    logic         fpu_in_ready_i;
    logic [95:0]  fpu_operands_o;
    logic [3:0]   fpu_op_o;
    logic         fpu_op_mod_o;
    logic         fpu_vec_op_o;
    logic [2:0]   fpu_rnd_mode_o;
    logic [2:0]   fpu_src_fmt_o;
    logic [2:0]   fpu_dst_fmt_o;
    logic [1:0]   fpu_int_fmt_o;
    logic [8:0]   fpu_tag_o;
    logic         fpu_out_valid_i;
    logic         fpu_out_ready_o;
    logic [31:0]  fpu_result_i;
    logic [4:0]   fpu_status_i;
    logic [8:0]   fpu_tag_i;
    logic         fpu_flush_o;
    logic         busy_o;
    logic [2:0]   credits_o;

    int tests = 0;
    int fails = 0;

    apu_fpu_credit_adapter dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o), .apu_ID_i(apu_ID_i),
        .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
        .apu_rready_i(apu_rready_i), .apu_rvalid_o(apu_rvalid_o), .apu_rdata_o(apu_rdata_o),
        .apu_rflags_o(apu_rflags_o), .apu_rID_o(apu_rID_o),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_op_mod_o(fpu_op_mod_o),
        .fpu_vec_op_o(fpu_vec_op_o), .fpu_rnd_mode_o(fpu_rnd_mode_o),
        .fpu_src_fmt_o(fpu_src_fmt_o), .fpu_dst_fmt_o(fpu_dst_fmt_o),
        .fpu_int_fmt_o(fpu_int_fmt_o), .fpu_tag_o(fpu_tag_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .fpu_flush_o(fpu_flush_o), .busy_o(busy_o), .credits_o(credits_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU model: fixed latency 2, result = op0 ^ op1, status = tag[4:0], drops work on flush.
    logic        s1_v, s2_v;
    logic [8:0]  s1_tag, s2_tag;
    logic [31:0] s1_res, s2_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s2_v <= 1'b0;
            s1_tag <= '0; s2_tag <= '0;
            s1_res <= '0; s2_res <= '0;
        end else if (fpu_flush_o) begin
            s1_v <= 1'b0; s2_v <= 1'b0;
        end else begin
            s1_v   <= fpu_in_valid_o && fpu_in_ready_i;
            s1_tag <= fpu_tag_o;
            s1_res <= fpu_operands_o[31:0] ^ fpu_operands_o[63:32];
            s2_v   <= s1_v;
            s2_tag <= s1_tag;
            s2_res <= s1_res;
        end
    end

    assign fpu_out_valid_i = s2_v;
    assign fpu_result_i    = s2_res;
    assign fpu_status_i    = s2_tag[4:0];
    assign fpu_tag_i       = s2_tag;

    function automatic logic [31:0] op0_of(input logic [8:0] id);
        return 32'h1000_0000 + 32'(id) * 32'd3;
    endfunction

    function automatic logic [31:0] op1_of(input logic [8:0] id);
        return ~32'(id);
    endfunction

    function automatic logic [31:0] res_of(input logic [8:0] id);
        return op0_of(id) ^ op1_of(id);
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [8:0] id);
        apu_req_i      = 1'b1;
        apu_ID_i       = id;
        apu_operands_i = {32'hDEAD_BEEF, op1_of(id), op0_of(id)};
    endtask

    initial begin
        rst_n          = 1'b0;
        flush_i        = 1'b0;
        apu_req_i      = 1'b0;
        apu_ID_i       = '0;
        apu_operands_i = '0;
        apu_op_i       = '0;
        apu_flags_i    = '0;
        apu_rready_i   = 1'b0;
        fpu_in_ready_i = 1'b1;

        // Reset values.
        #12;
        chk("rst_rvalid", 96'(apu_rvalid_o), 96'(0));
        chk("rst_busy", 96'(busy_o), 96'(0));
        chk("rst_credits", 96'(credits_o), 96'(0));
        chk("rst_rdata", 96'(apu_rdata_o), 96'(0));
        chk("rst_rflags", 96'(apu_rflags_o), 96'(0));
        chk("rst_rid", 96'(apu_rID_o), 96'(0));
        chk("rst_gnt", 96'(apu_gnt_o), 96'(1));
        chk("rst_in_valid", 96'(fpu_in_valid_o), 96'(0));
        chk("rst_out_ready", 96'(fpu_out_ready_o), 96'(1));
        rst_n = 1'b1;
        next_cycle();

        // Single op with decode check; rvalid three cycles after the request.
        apu_rready_i = 1'b1;
        apu_op_i     = 6'b10_0011;
        apu_flags_i  = {4'hA, 11'b01_001_000_100};
        drive_req(9'h015);
        settle();
        chk("single_gnt", 96'(apu_gnt_o), 96'(1));
        chk("single_in_valid", 96'(fpu_in_valid_o), 96'(1));
        chk("dec_vec", 96'(fpu_vec_op_o), 96'(1));
        chk("dec_mod", 96'(fpu_op_mod_o), 96'(0));
        chk("dec_op", 96'(fpu_op_o), 96'(3));
        chk("dec_int", 96'(fpu_int_fmt_o), 96'(1));
        chk("dec_src", 96'(fpu_src_fmt_o), 96'(1));
        chk("dec_dst", 96'(fpu_dst_fmt_o), 96'(0));
        chk("dec_rnd", 96'(fpu_rnd_mode_o), 96'(4));
        chk("dec_tag", 96'(fpu_tag_o), 96'(9'h015));
        chk("dec_operands", fpu_operands_o, {32'hDEAD_BEEF, op1_of(9'h015), op0_of(9'h015)});
        next_cycle();
        apu_req_i = 1'b0;
        settle();
        chk("single_c1_credits", 96'(credits_o), 96'(1));
        chk("single_c1_busy", 96'(busy_o), 96'(1));
        chk("single_c1_rvalid", 96'(apu_rvalid_o), 96'(0));
        next_cycle();
        settle();
        chk("single_c2_rvalid", 96'(apu_rvalid_o), 96'(0));
        next_cycle();
        settle();
        chk("single_c3_rvalid", 96'(apu_rvalid_o), 96'(1));
        chk("single_c3_rid", 96'(apu_rID_o), 96'(9'h015));
        chk("single_c3_rdata", 96'(apu_rdata_o), 96'(res_of(9'h015)));
        chk("single_c3_rflags", 96'(apu_rflags_o), 96'(5'h15));
        next_cycle();
        settle();
        chk("single_c4_credits", 96'(credits_o), 96'(0));
        chk("single_c4_busy", 96'(busy_o), 96'(0));
        chk("single_c4_rvalid", 96'(apu_rvalid_o), 96'(0));
        next_cycle();

        // Backpressure: four credits, fifth request waits for the first pop.
        apu_rready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_req(9'(i));
            settle();
            chk($sformatf("bp_gnt_%0d", i), 96'(apu_gnt_o), 96'(1));
            next_cycle();
        end
        drive_req(9'd5);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("bp_full_gnt_%0d", k), 96'(apu_gnt_o), 96'(0));
            chk($sformatf("bp_full_in_valid_%0d", k), 96'(fpu_in_valid_o), 96'(0));
            chk($sformatf("bp_full_credits_%0d", k), 96'(credits_o), 96'(4));
            next_cycle();
        end
        apu_rready_i = 1'b1;
        settle();
        chk("bp_pop1_gnt", 96'(apu_gnt_o), 96'(0));
        chk("bp_pop1_rid", 96'(apu_rID_o), 96'(1));
        next_cycle();
        settle();
        chk("bp_pop2_gnt", 96'(apu_gnt_o), 96'(1));
        chk("bp_pop2_rid", 96'(apu_rID_o), 96'(2));
        chk("bp_pop2_credits", 96'(credits_o), 96'(3));
        next_cycle();
        apu_req_i = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            settle();
            chk($sformatf("bp_order_rvalid_%0d", k), 96'(apu_rvalid_o), 96'(1));
            chk($sformatf("bp_order_rid_%0d", k), 96'(apu_rID_o), 96'(k));
            chk($sformatf("bp_order_rdata_%0d", k), 96'(apu_rdata_o), 96'(res_of(9'(k))));
            chk($sformatf("bp_order_credits_%0d", k), 96'(credits_o), 96'(6 - k));
            next_cycle();
        end
        settle();
        chk("bp_drained_rvalid", 96'(apu_rvalid_o), 96'(0));
        chk("bp_drained_credits", 96'(credits_o), 96'(0));
        next_cycle();

        // Steady state: continuous issue and pop, cnt holds at 3, FIFO wraps.
        apu_rready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_req(9'(9'h040 + i));
            settle();
            chk($sformatf("ss_gnt_%0d", i), 96'(apu_gnt_o), 96'(1));
            chk($sformatf("ss_credits_%0d", i), 96'(credits_o), 96'((i < 3) ? i : 3));
            if (i >= 3) begin
                chk($sformatf("ss_rvalid_%0d", i), 96'(apu_rvalid_o), 96'(1));
                chk($sformatf("ss_rid_%0d", i), 96'(apu_rID_o), 96'(9'h040 + i - 3));
                chk($sformatf("ss_rdata_%0d", i), 96'(apu_rdata_o),
                    96'(res_of(9'(9'h040 + i - 3))));
            end
            next_cycle();
        end
        apu_req_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            settle();
            chk($sformatf("ss_tail_rid_%0d", j), 96'(apu_rID_o), 96'(9'h040 + 17 + j));
            chk($sformatf("ss_tail_credits_%0d", j), 96'(credits_o), 96'(3 - j));
            next_cycle();
        end
        settle();
        chk("ss_end_credits", 96'(credits_o), 96'(0));
        next_cycle();

        // Flush with one result buffered and two in the FPU.
        apu_rready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(9'(9'h101 + i));
            next_cycle();
        end
        drive_req(9'h104);
        flush_i = 1'b1;
        settle();
        chk("fl_flush_o", 96'(fpu_flush_o), 96'(1));
        chk("fl_gnt", 96'(apu_gnt_o), 96'(0));
        chk("fl_in_valid", 96'(fpu_in_valid_o), 96'(0));
        chk("fl_credits_before", 96'(credits_o), 96'(3));
        chk("fl_rvalid_before", 96'(apu_rvalid_o), 96'(1));
        next_cycle();
        flush_i   = 1'b0;
        apu_req_i = 1'b0;
        settle();
        chk("fl_flush_o_low", 96'(fpu_flush_o), 96'(0));
        chk("fl_credits_after", 96'(credits_o), 96'(0));
        chk("fl_rvalid_after", 96'(apu_rvalid_o), 96'(0));
        chk("fl_busy_after", 96'(busy_o), 96'(0));
        chk("fl_gnt_after", 96'(apu_gnt_o), 96'(1));
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            settle();
            chk($sformatf("fl_quiet_rvalid_%0d", k), 96'(apu_rvalid_o), 96'(0));
        end
        next_cycle();
        apu_rready_i = 1'b1;
        drive_req(9'h1C5);
        next_cycle();
        apu_req_i = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        chk("fl_next_rvalid", 96'(apu_rvalid_o), 96'(1));
        chk("fl_next_rid", 96'(apu_rID_o), 96'(9'h1C5));
        next_cycle();
        settle();
        chk("fl_next_credits", 96'(credits_o), 96'(0));
        next_cycle();

        // Asynchronous reset with two credits in use.
        apu_rready_i = 1'b0;
        drive_req(9'h0A1);
        next_cycle();
        drive_req(9'h0A2);
        next_cycle();
        apu_req_i = 1'b0;
        settle();
        chk("ar_credits_before", 96'(credits_o), 96'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_credits", 96'(credits_o), 96'(0));
        chk("ar_busy", 96'(busy_o), 96'(0));
        chk("ar_rvalid", 96'(apu_rvalid_o), 96'(0));
        chk("ar_rid", 96'(apu_rID_o), 96'(0));
        chk("ar_rdata", 96'(apu_rdata_o), 96'(0));
        #1;
        rst_n = 1'b1;
        next_cycle();
        apu_rready_i = 1'b1;
        drive_req(9'h1AB);
        settle();
        chk("ar_post_gnt", 96'(apu_gnt_o), 96'(1));
        next_cycle();
        apu_req_i = 1'b0;
        settle();
        chk("ar_post_c1_rvalid", 96'(apu_rvalid_o), 96'(0));
        next_cycle();
        settle();
        chk("ar_post_c2_rvalid", 96'(apu_rvalid_o), 96'(0));
        next_cycle();
        settle();
        chk("ar_post_rvalid", 96'(apu_rvalid_o), 96'(1));
        chk("ar_post_rid", 96'(apu_rID_o), 96'(9'h1AB));
        chk("ar_post_rdata", 96'(apu_rdata_o), 96'(res_of(9'h1AB)));
        next_cycle();
        settle();
        chk("ar_post_credits", 96'(credits_o), 96'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apu_fpu_credit_adapter.md
# apu_fpu_credit_adapter

APU-side adapter between the shared FPU interconnect and an fpnew-style FPU core with valid/ready handshakes. Decodes APU opcode and flag words into FPU control fields and, unlike a direct hookup, honours `apu_rready_i` through a response FIFO sized by `RESP_DEPTH`. A credit counter caps in-flight plus buffered operations at `RESP_DEPTH`, so the FPU output is never back-pressured. It also adds flush and busy reporting.

## Interface
- `ID_WIDTH`, 9: transaction ID / FPU tag width.
- `NB_ARGS`, 3: operand count.
- `DATA_WIDTH`, 32: operand/result width.
- `OPCODE_WIDTH`, 6: APU opcode width, layout {vec, mod, op[3:0]}.
- `FLAGS_IN_WIDTH`, 15: must be ≥11; layout [10:0] = {int_fmt[1:0], src_fmt[2:0], dst_fmt[2:0], rnd[2:0]}; bits above 10 ignored.
- `FLAGS_OUT_WIDTH`, 5: FPU status width.
- `RESP_DEPTH`, 4: response FIFO depth and credit limit, ≥1.
- `clk` in 1: clock. `rst_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: discard all outstanding work.
- `apu_req_i` in 1, `apu_gnt_o` out 1: request handshake.
- `apu_ID_i` in ID_WIDTH; `apu_operands_i` in NB_ARGS×DATA_WIDTH; `apu_op_i` in OPCODE_WIDTH; `apu_flags_i` in FLAGS_IN_WIDTH.
- `apu_rready_i` in 1, `apu_rvalid_o` out 1: response handshake.
- `apu_rdata_o` out DATA_WIDTH; `apu_rflags_o` out FLAGS_OUT_WIDTH; `apu_rID_o` out ID_WIDTH.
- `fpu_in_valid_o` out 1, `fpu_in_ready_i` in 1: FPU issue handshake.
- `fpu_operands_o` out NB_ARGS×DATA_WIDTH; `fpu_op_o` out 4; `fpu_op_mod_o` out 1; `fpu_vec_op_o` out 1; `fpu_rnd_mode_o` out 3; `fpu_src_fmt_o` out 3; `fpu_dst_fmt_o` out 3; `fpu_int_fmt_o` out 2; `fpu_tag_o` out ID_WIDTH.
- `fpu_out_valid_i` in 1, `fpu_out_ready_o` out 1: FPU result handshake.
- `fpu_result_i` in DATA_WIDTH; `fpu_status_i` in FLAGS_OUT_WIDTH; `fpu_tag_i` in ID_WIDTH.
- `fpu_flush_o` out 1: flush to FPU.
- `busy_o` out 1: credits in use.
- `credits_o` out $clog2(RESP_DEPTH+1): current in-use count.

## Operation
- Field decode is combinational pass-through: {fpu_vec_op_o, fpu_op_mod_o, fpu_op_o} = apu_op_i; {int, src, dst, rnd} = apu_flags_i[10:0]. Operands and ID feed `fpu_operands_o` and `fpu_tag_o`.
- Credit counter `cnt` (0..RESP_DEPTH) counts ops issued and not yet popped by the APU.
- `can_issue` = cnt < RESP_DEPTH && !flush_i.
- `fpu_in_valid_o` = apu_req_i && can_issue.
- `apu_gnt_o` = fpu_in_ready_i && can_issue, independent of apu_req_i.
- issue = apu_req_i && apu_gnt_o.
- Response FIFO: RESP_DEPTH entries of {result, status, tag}.
  - Push when fpu_out_valid_i && !flush_i.
  - Pop when apu_rvalid_o && apu_rready_i.
  - Strict FIFO order; the tag is stored, not re-sorted.
- `fpu_out_ready_o` is tied to 1. Credits guarantee space; push on full without a same-cycle pop is a design error and is flagged by an assertion.
- cnt_next = cnt + issue − pop. Simultaneous issue and pop leaves cnt unchanged.
- Flush (`flush_i`=1 for one or more cycles):
  - `fpu_flush_o` = flush_i combinationally.
  - FIFO pointers and cnt clear to 0 on the next edge.
  - Issue and push are blocked during flush.
  - The FPU core is required to drop in-flight ops on flush; any `fpu_out_valid_i` in the flush cycle is discarded.
- `apu_rdata_o`, `apu_rflags_o`, `apu_rID_o` show the FIFO head; their value is don't-care when `apu_rvalid_o`=0.
- busy_o = (cnt != 0). credits_o = cnt.

## Timing
- Reset values: cnt=0 and FIFO empty, so `apu_rvalid_o`=0, `busy_o`=0, `credits_o`=0, `apu_rdata_o`/`apu_rflags_o`/`apu_rID_o`=0. The combinational outputs `apu_gnt_o` and `fpu_in_valid_o` follow their equations with cnt=0.
- Reset mid-operation: all state clears asynchronously; results returning after reset deassertion are pushed normally.
- Request path: zero added latency; the grant is in the same cycle as the request.
- Response path: an FPU result at edge N is registered into the FIFO, giving `apu_rvalid_o`=1 from cycle N+1. Total latency = FPU latency + 1.
- FIFO memory is registered with no bypass. Pointers wrap modulo RESP_DEPTH; full/empty use the count.
- When cnt == RESP_DEPTH, gnt=0 even if a pop happens that cycle. The grant returns in the cycle after the pop, because it depends on the registered cnt.
- apu_rvalid_o holds, with data stable, until the pop.

## Test plan
- Single op, FPU model latency 2, rready=1: req at cycle 0 with ID=0x15 → gnt at 0, fpu_in_valid_o=1, rvalid at cycle 3, rID=0x15, cnt back to 0 at cycle 4.
- Decode: apu_op_i=6'b10_0011, flags[10:0]=11'b01_001_000_100 → vec=1, mod=0, op=3, int=1, src=1, dst=0, rnd=4.
- Backpressure, RESP_DEPTH=4, rready=0: 5 back-to-back reqs → 4 granted, 5th sees gnt=0, credits_o=4. Then rready=1 → rIDs pop in issue order, and the 5th is granted the cycle after the first pop.
- Steady state at full: issue and pop in the same cycle with cnt=3 → cnt stays 3, no data loss, and the FIFO wraps over 20 ops with order preserved.
- Flush with 3 ops outstanding (1 in FIFO, 2 in FPU): flush_i pulse → fpu_flush_o=1 same cycle, gnt=0, then cnt=0, rvalid=0, busy_o=0; next op completes normally.
- Async reset asserted with cnt=2 → all outputs at reset values immediately; first post-reset op returns with correct ID.
